jt12_pres_ctl: RTL
==================

// Module: jt12_pres_ctl
// PURPOSE
//  Prescaler command controller for the FM/SSG/ADPCM clock divider. Decodes CPU
//  address writes 0x2D/0x2E/0x2F (YM2608 prescaler commands), computes the
//  2-bit divider setting, and applies it only on a divider boundary to avoid
//  runt enables. Sits between the CPU bus decoder and the clock divider's
//  div_setting input; busy tells the CPU interface a switchover is in flight.
// PARAMETERS
//  FIXED_DIV    0   1: ignore all commands, div_setting held at 2'b10 (YM2610)
//  SETTLE_CEN   12  cen pulses busy stays high after a new setting is applied
//  TIMEOUT_CEN  15  cen pulses to wait for a boundary before forcing the apply
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous reset, active low
//  cen          in   1  chip clock enable (same one that feeds the divider)
//  wr           in   1  CPU write strobe, one clk wide
//  a0           in   1  0 = address write, 1 = data write
//  part         in   1  register bank, 0 = bank I
//  din          in   8  CPU data bus
//  clk_en_in    in   1  divider's prescaled FM enable (boundary marker)
//  div_setting  out  2  setting to the divider
//  chg          out  1  one-clk pulse when div_setting changes
//  busy         out  1  high from command accept until settle ends
// BEHAVIOUR
//  Reset: div_setting=2'b10, chg=0, busy=0, state IDLE, queue empty, counters 0.
//  Command = wr & ~a0 & ~part & din in {2D,2E,2F}. Sampled on posedge clk; cen is
//   ignored. Data writes, bank II writes and other addresses are ignored.
//  Merge rule on base B: 2D -> B|2'b10; 2E -> B|2'b01; 2F -> 2'b00.
//  FSM:
//   IDLE: on command, tgt=merge(div_setting), busy=1 next clk, go to PEND, tmo=0.
//   PEND: on command, tgt=merge(tgt). Apply when clk_en_in=1, or when cen=1 and
//    tmo==TIMEOUT_CEN-1. Otherwise tmo++ on each cen. On apply: div_setting<=tgt
//    next edge. chg=1 for that clk only if tgt!=old value. Go to SETTLE, scnt=0.
//   SETTLE: scnt++ on each cen. On command, qtgt=merge(queue ? qtgt : tgt) and
//    set queue. When cen=1 and scnt==SETTLE_CEN-1: if queue, go to PEND with
//    tgt=qtgt, clear queue, tmo=0, busy held high; else go to IDLE, busy=0.
//  A command and the apply condition in the same PEND clk: merge first, then
//   apply the merged value.
//  A command and the settle end in the same clk: the command joins the queue, so
//   the FSM enters PEND.
//  Queue is one deep. Later commands merge into it and never drop.
//  Latency: IDLE command with clk_en_in already high on the next clk gives
//   div_setting updated 2 clks after wr.
//  Counters: tmo/scnt are wide enough for the parameter, saturate, no wrap.
//  FIXED_DIV=1: FSM stays in IDLE, busy=0, chg=0, div_setting=2'b10.
//  rst_n low at any point: all state returns to reset values immediately.
// TESTING
//  1 Reset, then write 2F with clk_en_in pulsing every 6 cen -> div_setting=00 at
//    first clk_en_in, chg one clk, busy low 12 cen later.
//  2 2F applied, then write 2D and 2E back to back in PEND -> single apply of 11,
//    exactly one chg pulse.
//  3 Write 2D during SETTLE of a previous 2F -> busy stays high; 10 applied after
//    the next boundary following settle end.
//  4 clk_en_in held low, write 2F -> forced apply on 15th cen; cen held low ->
//    no apply.
//  5 Data write 0x2F, bank II address 0x2F, address 0x2C -> no state change,
//    busy=0.
//  6 rst_n pulsed low in PEND and in SETTLE -> div_setting=10, busy=0 at once;
//    FIXED_DIV=1 ignores 2F.

Source files
------------

// File: rtl/jt12_pres_ctl.sv
// Prescaler command controller: merges 2D/2E/2F writes into a divider
// setting and applies it on a clk_en_in boundary, with settle/queue.
module jt12_pres_ctl #(
  parameter int FIXED_DIV   = 0,
  parameter int SETTLE_CEN  = 12,
  parameter int TIMEOUT_CEN = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cen,
  input  logic       wr,
  input  logic       a0,
  input  logic       part,
  input  logic [7:0] din,
  input  logic       clk_en_in,
  output logic [1:0] div_setting,
  output logic       chg,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CEN + 1);
  localparam int SW = $clog2(SETTLE_CEN + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CEN - 1);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    SETTLE
  } st_t;

  st_t           st_q, st_d;
  logic [1:0]    div_q, div_d;
  logic [1:0]    tgt_q, tgt_d;
  logic [1:0]    qtgt_q, qtgt_d;
  logic          queue_q, queue_d;
  logic          chg_q, chg_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [SW-1:0] scnt_q, scnt_d;

  logic       cmd;
  logic       apply;
  logic       sdone;
  logic       qany;
  logic [1:0] ptgt;
  logic [1:0] qnew;

  function automatic logic [1:0] merge(
    input logic [1:0] b,
    input logic [1:0] c
  );
    unique case (1'b1)
      c == 2'b01: merge = b | 2'b10;
      c == 2'b10: merge = b | 2'b01;
      default:    merge = 2'b00;
    endcase
  endfunction

  assign cmd = (FIXED_DIV == 0) && wr && !a0 && !part &&
               (din == 8'h2D || din == 8'h2E || din == 8'h2F);

  // Pending target and queue target already include a same-clk command
  assign ptgt  = cmd ? merge(tgt_q, din[1:0]) : tgt_q;
  assign qnew  = cmd ? merge(queue_q ? qtgt_q : tgt_q, din[1:0])
                     : qtgt_q;
  assign qany  = queue_q | cmd;
  assign apply = clk_en_in | (cen & (tmo_q == TLAST));
  assign sdone = cen & (scnt_q == SLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      div_q   <= 2'b10;
      tgt_q   <= 2'b00;
      qtgt_q  <= 2'b00;
      queue_q <= 1'b0;
      chg_q   <= 1'b0;
      tmo_q   <= '0;
      scnt_q  <= '0;
    end else begin
      st_q    <= st_d;
      div_q   <= div_d;
      tgt_q   <= tgt_d;
      qtgt_q  <= qtgt_d;
      queue_q <= queue_d;
      chg_q   <= chg_d;
      tmo_q   <= tmo_d;
      scnt_q  <= scnt_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    div_d   = div_q;
    tgt_d   = tgt_q;
    qtgt_d  = qtgt_q;
    queue_d = queue_q;
    chg_d   = 1'b0;
    tmo_d   = tmo_q;
    scnt_d  = scnt_q;
    unique case (st_q)
      IDLE: begin
        if (cmd) begin
          tgt_d = merge(div_q, din[1:0]);
          tmo_d = '0;
          st_d  = PEND;
        end
      end
      PEND: begin
        tgt_d = ptgt;
        if (apply) begin
          div_d  = ptgt;
          chg_d  = (ptgt != div_q);
          scnt_d = '0;
          st_d   = SETTLE;
        end else if (cen && tmo_q != TLAST) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SETTLE: begin
        if (cmd) begin
          qtgt_d  = qnew;
          queue_d = 1'b1;
        end
        if (cen && scnt_q != SLAST) begin
          scnt_d = scnt_q + 1'b1;
        end
        if (sdone) begin
          if (qany) begin
            tgt_d   = qnew;
            queue_d = 1'b0;
            tmo_d   = '0;
            st_d    = PEND;
          end else begin
            st_d = IDLE;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    div_setting = div_q;
    chg         = chg_q;
    busy        = (st_q != IDLE);
  end

endmodule
